// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared states, owner encoding and parameter defaults
package mem_port_arbiter_pkg;

    localparam int RAM_LAT_DEFAULT    = 1;
    localparam int STARVE_MAX_DEFAULT = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        DONE   = 2'd3
    } state_t;

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_DMA = 1'b1
    } owner_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - CPU, DMA and RAM port bundle of the arbiter
interface mem_port_arbiter_if;

    logic       cpu_rd;
    logic       cpu_wr;
    logic [7:0] cpu_addr;
    logic [7:0] cpu_wdata;
    logic [7:0] cpu_rdata;
    logic       cpu_ready;

    logic       dma_req;
    logic       dma_we;
    logic [7:0] dma_addr;
    logic [7:0] dma_wdata;
    logic [7:0] dma_rdata;
    logic       dma_gnt;
    logic       dma_done;

    logic       ram_en;
    logic       ram_we;
    logic [7:0] ram_addr;
    logic [7:0] ram_wdata;
    logic [7:0] ram_rdata;

    logic       err;

    modport master (
        output cpu_rd, cpu_wr, cpu_addr, cpu_wdata,
        output dma_req, dma_we, dma_addr, dma_wdata,
        output ram_rdata,
        input  cpu_rdata, cpu_ready, dma_rdata, dma_gnt, dma_done,
        input  ram_en, ram_we, ram_addr, ram_wdata, err
    );

    modport slave (
        input  cpu_rd, cpu_wr, cpu_addr, cpu_wdata,
        input  dma_req, dma_we, dma_addr, dma_wdata,
        input  ram_rdata,
        output cpu_rdata, cpu_ready, dma_rdata, dma_gnt, dma_done,
        output ram_en, ram_we, ram_addr, ram_wdata, err
    );

endinterface

// File: rtl/mem_port_arbiter_arb_priority.sv
// rtl/mem_port_arbiter_arb_priority.sv - CPU-first arbitration with DMA starvation counter
module arb_priority
    import mem_port_arbiter_pkg::*;
#(
    parameter int STARVE_MAX = STARVE_MAX_DEFAULT
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   cpu_req,
    input  logic   dma_req,
    input  logic   arb_en,
    output owner_t winner
);

    localparam logic [3:0] SMAX = 4'(STARVE_MAX);

    logic [3:0] starve_cnt;

    assign winner = (dma_req && (!cpu_req || starve_cnt == SMAX)) ? OWN_DMA : OWN_CPU;

    // Counter only moves on an actual arbitration, so held requests in DONE do not age it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            starve_cnt <= 4'd0;
        end else if (arb_en) begin
            if (winner == OWN_DMA) begin
                starve_cnt <= 4'd0;
            end else if (dma_req && starve_cnt != SMAX) begin
                starve_cnt <= starve_cnt + 4'd1;
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - single-port RAM arbiter between a CPU and a DMA requester
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int RAM_LAT    = RAM_LAT_DEFAULT,
    parameter int STARVE_MAX = STARVE_MAX_DEFAULT
) (
    input  logic               clk,
    input  logic               reset,
    mem_port_arbiter_if.slave  bus
);

    // RAM_LAT counts the ACCESS cycle: ram_rdata is valid RAM_LAT-1 cycles after ram_en.
    localparam logic [1:0] WAIT_LAST = (RAM_LAT > 1) ? 2'(RAM_LAT - 2) : 2'd0;

    state_t     state_q, state_d;
    owner_t     owner_q;
    owner_t     winner;
    logic [7:0] addr_q, wdata_q;
    logic       we_q;
    logic [1:0] wait_q;
    logic [7:0] cpu_rdata_q, dma_rdata_q;
    logic       err_q;
    logic       cpu_req, arb_en, capture;

    assign cpu_req = bus.cpu_rd | bus.cpu_wr;
    assign arb_en  = (state_q == IDLE) && (cpu_req || bus.dma_req);
    assign capture = ((state_q == ACCESS) && !we_q && (RAM_LAT == 1)) ||
                     ((state_q == WAIT) && (wait_q == WAIT_LAST));

    arb_priority #(.STARVE_MAX(STARVE_MAX)) u_arb (
        .clk     (clk),
        .reset   (reset),
        .cpu_req (cpu_req),
        .dma_req (bus.dma_req),
        .arb_en  (arb_en),
        .winner  (winner)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            owner_q     <= OWN_CPU;
            addr_q      <= 8'h00;
            wdata_q     <= 8'h00;
            we_q        <= 1'b0;
            wait_q      <= 2'd0;
            cpu_rdata_q <= 8'h00;
            dma_rdata_q <= 8'h00;
            err_q       <= 1'b0;
        end else begin
            if (arb_en) begin
                owner_q <= winner;
                if (winner == OWN_DMA) begin
                    addr_q  <= bus.dma_addr;
                    wdata_q <= bus.dma_wdata;
                    we_q    <= bus.dma_we;
                end else begin
                    addr_q  <= bus.cpu_addr;
                    wdata_q <= bus.cpu_wdata;
                    we_q    <= bus.cpu_wr;
                end
            end
            if (state_q == ACCESS) begin
                wait_q <= 2'd0;
            end else if (state_q == WAIT) begin
                wait_q <= wait_q + 2'd1;
            end
            if (capture) begin
                if (owner_q == OWN_DMA) begin
                    dma_rdata_q <= bus.ram_rdata;
                end else begin
                    cpu_rdata_q <= bus.ram_rdata;
                end
            end
            if (bus.cpu_rd && bus.cpu_wr) begin
                err_q <= 1'b1;
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        bus.ram_en    = 1'b0;
        bus.cpu_ready = 1'b0;
        bus.dma_done  = 1'b0;
        bus.dma_gnt   = (owner_q == OWN_DMA) && (state_q != IDLE);
        case (state_q)
            IDLE: begin
                if (arb_en) state_d = ACCESS;
            end
            ACCESS: begin
                bus.ram_en = 1'b1;
                state_d    = (we_q || RAM_LAT == 1) ? DONE : WAIT;
            end
            WAIT: begin
                if (wait_q == WAIT_LAST) state_d = DONE;
            end
            DONE: begin
                bus.cpu_ready = (owner_q == OWN_CPU);
                bus.dma_done  = (owner_q == OWN_DMA);
                state_d       = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.ram_we    = bus.ram_en & we_q;
    assign bus.ram_addr  = addr_q;
    assign bus.ram_wdata = wdata_q;
    assign bus.cpu_rdata = cpu_rdata_q;
    assign bus.dma_rdata = dma_rdata_q;
    assign bus.err       = err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - scoreboard bench for mem_port_arbiter with a RAM_LAT=2 RAM model
module tb_mem_port_arbiter;
    import mem_port_arbiter_pkg::*;

    localparam int RAM_LAT = 2;

    typedef struct {
        bit         owner;
        bit         rd;
        logic [7:0] data;
        int         cyc;
    } cpl_t;

    typedef struct {
        bit         we;
        logic [7:0] addr;
        logic [7:0] wdata;
    } ram_t;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    cpl_t cq[$];
    ram_t rq[$];
    cpl_t me;
    ram_t mr;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_port_arbiter_if bus();

    mem_port_arbiter #(.RAM_LAT(RAM_LAT), .STARVE_MAX(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    // Registered-output RAM: data appears one cycle after the enable cycle (RAM_LAT=2).
    logic [7:0] mem [256];
    logic [7:0] rd_q = 8'h00;
    always @(posedge clk) begin
        if (bus.ram_en) begin
            if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
            else            rd_q <= mem[bus.ram_addr];
        end
    end
    assign bus.ram_rdata = rd_q;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%02h expected 0x%02h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (reset) begin
            if (bus.cpu_ready || bus.dma_done) begin
                if (cq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_cpl: cpu_ready=%b dma_done=%b with none expected (cycle %0d)",
                             bus.cpu_ready, bus.dma_done, cyc);
                end else begin
                    me = cq.pop_front();
                    check("cpl_owner", {6'b0, bus.cpu_ready, bus.dma_done}, {6'b0, ~me.owner, me.owner});
                    if (me.cyc >= 0) check_int("cpl_cycle", cyc, me.cyc);
                    if (me.rd) check("cpl_rdata", me.owner ? bus.dma_rdata : bus.cpu_rdata, me.data);
                end
            end
            if (bus.ram_en) begin
                if (rq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_ram_en: addr 0x%02h with none expected (cycle %0d)", bus.ram_addr, cyc);
                end else begin
                    mr = rq.pop_front();
                    check("ram_we", {7'b0, bus.ram_we}, {7'b0, mr.we});
                    check("ram_addr", bus.ram_addr, mr.addr);
                    if (mr.we) check("ram_wdata", bus.ram_wdata, mr.wdata);
                end
            end else begin
                check("ram_we_idle", {7'b0, bus.ram_we}, 8'h00);
            end
        end
    end

    task automatic push_ram(input bit we, input logic [7:0] a, input logic [7:0] wd);
        ram_t r;
        r.we = we; r.addr = a; r.wdata = wd;
        rq.push_back(r);
    endtask

    task automatic push_cpl(input bit owner, input bit rd, input logic [7:0] d, input int c);
        cpl_t e;
        e.owner = owner; e.rd = rd; e.data = d; e.cyc = c;
        cq.push_back(e);
    endtask

    task automatic cpu_op(input bit rd, input bit wr, input logic [7:0] a, input logic [7:0] wd,
                          input logic [7:0] exp);
        int k;
        bit seen;
        seen = 1'b0;
        @(posedge clk); #1;
        k = cyc;
        bus.cpu_rd = rd; bus.cpu_wr = wr; bus.cpu_addr = a; bus.cpu_wdata = wd;
        push_ram(wr, a, wd);
        push_cpl(1'b0, !wr, exp, k + (wr ? 2 : 1 + RAM_LAT));
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.cpu_ready) begin seen = 1'b1; break; end
        end
        bus.cpu_rd = 1'b0; bus.cpu_wr = 1'b0;
        if (!seen) begin
            checks++; errors++;
            $display("FAIL cpu_timeout: cpu_ready 0 expected 1 within 20 cycles");
        end
    endtask

    task automatic dma_op(input bit we, input logic [7:0] a, input logic [7:0] wd, input logic [7:0] exp);
        int k;
        bit seen;
        seen = 1'b0;
        @(posedge clk); #1;
        k = cyc;
        bus.dma_req = 1'b1; bus.dma_we = we; bus.dma_addr = a; bus.dma_wdata = wd;
        push_ram(we, a, wd);
        push_cpl(1'b1, !we, exp, k + (we ? 2 : 1 + RAM_LAT));
        @(negedge clk);
        check("dma_gnt_idle", {7'b0, bus.dma_gnt}, 8'h00);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("dma_gnt_busy", {7'b0, bus.dma_gnt}, 8'h01);
            if (bus.dma_done) begin seen = 1'b1; break; end
        end
        bus.dma_req = 1'b0;
        if (!seen) begin
            checks++; errors++;
            $display("FAIL dma_timeout: dma_done 0 expected 1 within 20 cycles");
        end
        @(negedge clk);
        check("dma_gnt_after", {7'b0, bus.dma_gnt}, 8'h00);
    endtask

    initial begin
        int n;
        bus.cpu_rd = 0; bus.cpu_wr = 0; bus.cpu_addr = 0; bus.cpu_wdata = 0;
        bus.dma_req = 0; bus.dma_we = 0; bus.dma_addr = 0; bus.dma_wdata = 0;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;

        #1;
        check("rst_cpu_ready", {7'b0, bus.cpu_ready}, 8'h00);
        check("rst_dma_done", {7'b0, bus.dma_done}, 8'h00);
        check("rst_dma_gnt", {7'b0, bus.dma_gnt}, 8'h00);
        check("rst_ram_en", {6'b0, bus.ram_en, bus.ram_we}, 8'h00);
        check("rst_err", {7'b0, bus.err}, 8'h00);
        check("rst_ram_addr", bus.ram_addr, 8'h00);
        check("rst_ram_wdata", bus.ram_wdata, 8'h00);
        check("rst_cpu_rdata", bus.cpu_rdata, 8'h00);
        check("rst_dma_rdata", bus.dma_rdata, 8'h00);
        repeat (2) @(negedge clk);
        reset = 1'b1;

        cpu_op(1'b0, 1'b1, 8'h10, 8'h5A, 8'h00);
        cpu_op(1'b1, 1'b0, 8'h10, 8'h00, 8'h5A);
        dma_op(1'b1, 8'hFF, 8'hC3, 8'h00);
        dma_op(1'b0, 8'hFF, 8'h00, 8'hC3);
        check("cpu_rdata_hold", bus.cpu_rdata, 8'h5A);

        // Both requesters held: the counter reached zero on the last DMA grant.
        @(posedge clk); #1;
        bus.cpu_wr = 1'b1; bus.cpu_addr = 8'h30; bus.cpu_wdata = 8'h11;
        bus.dma_req = 1'b1; bus.dma_we = 1'b1; bus.dma_addr = 8'h40; bus.dma_wdata = 8'h22;
        for (int i = 0; i < 10; i++) begin
            if (i % 5 == 4) begin push_ram(1'b1, 8'h40, 8'h22); push_cpl(1'b1, 1'b0, 8'h00, -1); end
            else            begin push_ram(1'b1, 8'h30, 8'h11); push_cpl(1'b0, 1'b0, 8'h00, -1); end
        end
        n = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.cpu_ready || bus.dma_done) n++;
            if (n == 10) break;
        end
        bus.cpu_wr = 1'b0; bus.dma_req = 1'b0; bus.dma_we = 1'b0;
        check_int("starve_cpl_count", n, 10);

        cpu_op(1'b1, 1'b1, 8'h20, 8'h77, 8'h00);
        check("err_set", {7'b0, bus.err}, 8'h01);
        cpu_op(1'b1, 1'b0, 8'h20, 8'h00, 8'h77);
        check("err_held", {7'b0, bus.err}, 8'h01);

        @(posedge clk); #1;
        bus.dma_req = 1'b1; bus.dma_we = 1'b0; bus.dma_addr = 8'h10;
        push_ram(1'b0, 8'h10, 8'h00);
        @(posedge clk);
        @(posedge clk); #1;
        check("pre_rst_state", {6'b0, dut.state_q}, {6'b0, WAIT});
        check("pre_rst_gnt", {7'b0, bus.dma_gnt}, 8'h01);
        reset = 1'b0;
        #1;
        check("mid_rst_state", {6'b0, dut.state_q}, {6'b0, IDLE});
        check("mid_rst_gnt", {7'b0, bus.dma_gnt}, 8'h00);
        check("mid_rst_done", {7'b0, bus.dma_done}, 8'h00);
        check("mid_rst_ram_en", {7'b0, bus.ram_en}, 8'h00);
        check("mid_rst_dma_rdata", bus.dma_rdata, 8'h00);
        check("mid_rst_cpu_rdata", bus.cpu_rdata, 8'h00);
        check("mid_rst_ram_addr", bus.ram_addr, 8'h00);
        check("mid_rst_err", {7'b0, bus.err}, 8'h00);
        bus.dma_req = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;

        cpu_op(1'b1, 1'b0, 8'h10, 8'h00, 8'h5A);
        repeat (4) @(negedge clk);
        check_int("cpl_queue_empty", cq.size(), 0);
        check_int("ram_queue_empty", rq.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
